// File: rtl/i2s_encode_pkg.sv
// rtl/i2s_encode_pkg.sv - shared constants, types and helpers for the I2S transmitter
package i2s_encode_pkg;

   // Default geometry, shared with the I2S receiver
   localparam int DEF_RESOLUTION = 24;
   localparam int DEF_SLOT_BITS  = 32;
   localparam int DEF_SCLK_DIV   = 4;

   // Word-select polarity: LRCK low carries the left channel
   localparam logic LRCK_LEFT  = 1'b0;
   localparam logic LRCK_RIGHT = 1'b1;

   // What the shift registers take at the start of a frame
   typedef enum logic [1:0] {
      LOAD_NONE    = 2'd0,
      LOAD_BUFFER  = 2'd1,
      LOAD_BYPASS  = 2'd2,
      LOAD_SILENCE = 2'd3
   } load_sel_e;

   // Counter width that stays legal for a modulus of 1
   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - SCLK divider, fall-event strobe, bit counter, LRCK and frame_start
module i2s_clkgen
   import i2s_encode_pkg::*;
#(
   parameter  int SLOT_BITS = DEF_SLOT_BITS,
   parameter  int SCLK_DIV  = DEF_SCLK_DIV,
   localparam int CW        = cnt_width(2 * SLOT_BITS)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          sclk,
   output logic          lrck,
   output logic          frame_start,
   output logic          fall,
   output logic          wrap,
   output logic [CW-1:0] cnt_next,
   output logic          lrck_next
);

   localparam int DW         = cnt_width(SCLK_DIV);
   localparam int FRAME_LAST = 2 * SLOT_BITS - 1;

   logic [DW-1:0] div_cnt;
   logic [CW-1:0] bit_cnt;
   logic          div_tc;

   // Terminal count of the half-period divider; SCLK toggles here
   assign div_tc    = (div_cnt == DW'(SCLK_DIV - 1));
   // A toggle taken while SCLK is high is a falling edge: the only point serial state moves
   assign fall      = div_tc && sclk;
   assign cnt_next  = (bit_cnt == CW'(FRAME_LAST)) ? '0 : bit_cnt + 1'b1;
   assign lrck_next = (cnt_next >= CW'(SLOT_BITS)) ? LRCK_RIGHT : LRCK_LEFT;
   assign wrap      = fall && (cnt_next == '0);

   // Half-period divider and SCLK toggle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (div_tc) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Frame position, word select and frame-start pulse, advanced on fall events
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= CW'(FRAME_LAST);
         lrck        <= LRCK_RIGHT;
         frame_start <= 1'b0;
      end else begin
         frame_start <= wrap;
         if (fall) begin
            bit_cnt <= cnt_next;
            lrck    <= lrck_next;
         end
      end
   end

endmodule

// File: rtl/i2s_encode.sv
// rtl/i2s_encode.sv - I2S master transmitter: holding buffer, shift registers, serial mux
module i2s_encode
   import i2s_encode_pkg::*;
#(
   parameter int RESOLUTION = DEF_RESOLUTION,
   parameter int SLOT_BITS  = DEF_SLOT_BITS,
   parameter int SCLK_DIV   = DEF_SCLK_DIV
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [RESOLUTION-1:0] data_in_L,
   input  logic [RESOLUTION-1:0] data_in_R,
   input  logic                  valid,
   output logic                  ready,
   output logic                  SCLK,
   output logic                  LRCK,
   output logic                  data_out,
   output logic                  frame_start,
   output logic                  underrun
);

   localparam int CW = cnt_width(2 * SLOT_BITS);

   logic                  fall;
   logic                  wrap;
   logic                  lrck_next;
   logic [CW-1:0]         cnt_next;

   logic                  full;
   logic                  full_next;
   logic                  accept;
   logic [RESOLUTION-1:0] buf_l;
   logic [RESOLUTION-1:0] buf_r;
   logic [RESOLUTION-1:0] sh_l;
   logic [RESOLUTION-1:0] sh_r;
   load_sel_e             load_sel;

   logic [CW-1:0]         slot_pos;
   logic                  in_window;
   logic [RESOLUTION-1:0] word;
   logic [RESOLUTION-1:0] word_aligned;
   logic                  next_bit;

   i2s_clkgen #(
      .SLOT_BITS (SLOT_BITS),
      .SCLK_DIV  (SCLK_DIV)
   ) u_clkgen (
      .clk         (CLK),
      .rst_n       (RST_N),
      .sclk        (SCLK),
      .lrck        (LRCK),
      .frame_start (frame_start),
      .fall        (fall),
      .wrap        (wrap),
      .cnt_next    (cnt_next),
      .lrck_next   (lrck_next)
   );

   // A pair offered on the frame-start edge with nothing buffered goes straight to the
   // shift registers instead of the buffer
   assign accept = valid && ready && !wrap;

   // Frame-start source selection and next buffer occupancy
   always_comb begin
      load_sel  = LOAD_NONE;
      full_next = full;
      if (wrap) begin
         if (full) begin
            load_sel = LOAD_BUFFER;
         end else if (valid) begin
            load_sel = LOAD_BYPASS;
         end else begin
            load_sel = LOAD_SILENCE;
         end
      end
      if (load_sel == LOAD_BUFFER) begin
         full_next = 1'b0;
      end else if (accept) begin
         full_next = 1'b1;
      end
   end

   // Holding buffer and registered ready flag
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         full  <= 1'b0;
         ready <= 1'b1;
         buf_l <= '0;
         buf_r <= '0;
      end else begin
         full  <= full_next;
         ready <= !full_next;
         if (accept) begin
            buf_l <= data_in_L;
            buf_r <= data_in_R;
         end
      end
   end

   // Shift registers change only at a frame start so the frame in flight stays intact
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sh_l <= '0;
         sh_r <= '0;
      end else begin
         case (load_sel)
            LOAD_BUFFER: begin
               sh_l <= buf_l;
               sh_r <= buf_r;
            end
            LOAD_BYPASS: begin
               sh_l <= data_in_L;
               sh_r <= data_in_R;
            end
            LOAD_SILENCE: begin
               sh_l <= '0;
               sh_r <= '0;
            end
            default: begin
               sh_l <= sh_l;
               sh_r <= sh_r;
            end
         endcase
      end
   end

   // Bit selection for the slot position reached at this fall event; position 0 is the
   // one-SCLK delay after the LRCK edge, positions past RESOLUTION are padding
   always_comb begin
      slot_pos     = (lrck_next == LRCK_RIGHT) ? cnt_next - CW'(SLOT_BITS) : cnt_next;
      in_window    = (slot_pos >= CW'(1)) && (slot_pos <= CW'(RESOLUTION));
      word         = (lrck_next == LRCK_RIGHT) ? sh_r : sh_l;
      word_aligned = word << (slot_pos - 1'b1);
      next_bit     = in_window && word_aligned[RESOLUTION-1];
   end

   // Serial data and underrun pulse
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         data_out <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= (load_sel == LOAD_SILENCE);
         if (fall) begin
            data_out <= next_bit;
         end
      end
   end

endmodule
